word_assembler_rx: RTL and testbench
====================================

# word_assembler_rx

Parametrised byte-to-word assembler that collects NUM_BYTES consecutive bytes from the UART receive path into one word. The byte order is selectable. A partial word is discarded after an inter-byte timeout. The completed word is presented on a valid/ready output port, and overruns are flagged. It sits between the uart_rx byte interface (o_Rx_DV / o_Rx_Byte) and any word-level consumer, such as a command decoder or a sensor register file.

## Interface
- NUM_BYTES, default 4: bytes per word; legal range 2..16.
- LSB_FIRST, default 1: 1 = first received byte lands in bits [7:0] (little endian); 0 = first byte lands in bits [W-1:W-8] (big endian).
- TIMEOUT_CLKS, default 8680: idle clocks tolerated between bytes of one word (4 byte-times at 217 clocks/bit); 0 disables the timeout.
- Derived: W = 8*NUM_BYTES; CW = $clog2(NUM_BYTES+1).

Ports:
- i_Clock  in  1  system clock; all logic is on posedge.
- i_Rst_L  in  1  asynchronous, active-low reset.
- i_Rx_DV  in  1  one-cycle byte strobe from uart_rx.
- i_Rx_Byte  in  8  byte from uart_rx; sampled only when i_Rx_DV=1.
- o_Word  out  W  assembled word; stable while o_Word_Valid=1.
- o_Word_Valid  out  1  word available; held until accepted.
- i_Word_Ready  in  1  consumer accepts o_Word when both valid and ready are 1.
- o_Timeout  out  1  one-cycle pulse: a partial word was discarded.
- o_Overrun  out  1  one-cycle pulse: a completed word was dropped because the output was full.
- o_Byte_Count  out  CW  bytes held in the current partial word (0..NUM_BYTES-1).

## Operation
- States:
  - IDLE: byte count is 0.
  - COLLECT: byte count is 1..NUM_BYTES-1.
  - The output stage is a separate one-entry register with flag o_Word_Valid.
- Byte placement: byte k (k = 0 is the first received byte) is written to bits [8k+7:8k] when LSB_FIRST=1, and to [W-8k-1:W-8k-8] when LSB_FIRST=0. Bits of the assembly register not yet written are don't-care.
- IDLE, i_Rx_DV=1: store byte 0, set count to 1, clear the timer, go to COLLECT.
- COLLECT, i_Rx_DV=1 with count < NUM_BYTES-1: store byte, increment count, clear the timer.
- COLLECT, i_Rx_DV=1 with count = NUM_BYTES-1 (completion):
  - Merge the final byte and form the full word.
  - Count goes to 0, state goes to IDLE.
  - The word is loaded into the output register if o_Word_Valid=0, or if o_Word_Valid=1 and i_Word_Ready=1 in the same cycle (back-to-back words allowed).
  - Otherwise the new word is dropped, the old o_Word is kept, and o_Overrun pulses.
- Timeout (TIMEOUT_CLKS > 0):
  - The timer increments on each COLLECT cycle with i_Rx_DV=0.
  - When the timer equals TIMEOUT_CLKS-1 with i_Rx_DV=0, discard the partial word: count goes to 0, state goes to IDLE, o_Timeout pulses.
  - If i_Rx_DV=1 in the expiry cycle, the byte wins: it is accepted and the timer clears.
- Timeout never occurs in IDLE. The output register has no timeout.
- Accept: o_Word_Valid=1 and i_Word_Ready=1 with no simultaneous load clears o_Word_Valid next cycle. o_Word keeps its last value.
- i_Word_Ready is ignored while o_Word_Valid=0.

## Timing
- Reset (i_Rst_L=0, asynchronous):
  - o_Word=0, o_Word_Valid=0, o_Timeout=0, o_Overrun=0, o_Byte_Count=0.
  - State IDLE, timer 0.
  - Reset mid-word discards the partial word with no o_Timeout pulse.
- Latency: o_Word_Valid=1 and the new o_Word appear on the first clock edge after the edge that samples the final i_Rx_DV (1 cycle).
- o_Timeout asserts TIMEOUT_CLKS cycles after the last accepted byte and lasts exactly 1 cycle.
- o_Overrun asserts in the same cycle as o_Word_Valid would have loaded and lasts 1 cycle.
- o_Byte_Count updates 1 cycle after each i_Rx_DV.
- Throughput: one byte per clock is supported; i_Rx_DV may be high on consecutive cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- NUM_BYTES=4, LSB_FIRST=1: bytes 0x11,0x22,0x33,0x44 with i_Word_Ready=1 -> o_Word=0x44332211, o_Word_Valid high for exactly 1 cycle, o_Byte_Count sequence 1,2,3,0.
- LSB_FIRST=0, same bytes -> o_Word=0x11223344. With NUM_BYTES=2, bytes 0xAB,0xCD -> o_Word=0xABCD.
- TIMEOUT_CLKS=100: send 0x01,0x02, then idle 100 clocks -> o_Timeout pulses 100 cycles after 0x02, o_Byte_Count=0. Then send 0xA0..0xA3 -> o_Word=0xA3A2A1A0.
- Timeout boundary: a byte arrives exactly on the expiry cycle (99 idle cycles after the previous byte) -> no o_Timeout, count increments.
- i_Word_Ready=0: send 8 bytes 0x01..0x08 -> first o_Word=0x04030201 held, o_Overrun pulses once on byte 0x08, o_Word unchanged. Raise ready together with the next completion -> the new word loads with no overrun.
- Assert i_Rst_L=0 after 2 of 4 bytes, then release and send 4 bytes 0x55,0x66,0x77,0x88 -> all outputs 0 during reset, no o_Timeout, then o_Word=0x88776655.

Source files
------------

// File: rtl/word_assembler_rx.sv
// word_assembler_rx
// Packs NUM_BYTES consecutive UART bytes into one word (little or big endian),
// drops a partial word after an inter-byte idle timeout, and presents the
// finished word through a one-entry valid/ready output register. A word that
// completes while the output is still full and not being accepted is dropped
// and flagged on o_Overrun.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no partial word held, byte count 0, timer stopped
//   COLLECT | 1..NUM_BYTES-1 bytes held, timer counts idle clocks
module word_assembler_rx #(
    parameter int NUM_BYTES    = 4,
    parameter int LSB_FIRST    = 1,
    parameter int TIMEOUT_CLKS = 8680,
    localparam int W           = 8 * NUM_BYTES,
    localparam int CW          = $clog2(NUM_BYTES + 1)
) (
    input  logic          i_Clock,
    input  logic          i_Rst_L,
    input  logic          i_Rx_DV,
    input  logic [7:0]    i_Rx_Byte,
    output logic [W-1:0]  o_Word,
    output logic          o_Word_Valid,
    input  logic          i_Word_Ready,
    output logic          o_Timeout,
    output logic          o_Overrun,
    output logic [CW-1:0] o_Byte_Count
);

    // Timer only has to reach TIMEOUT_CLKS-1; keep at least one bit so a
    // disabled timeout still elaborates cleanly.
    localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0] T_LAST   = TW'((TIMEOUT_CLKS > 0) ? TIMEOUT_CLKS - 1 : 0);
    localparam logic [CW-1:0] CNT_LAST = CW'(NUM_BYTES - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [W-1:0]  asm_q, asm_d;
    logic [W-1:0]  word_q, word_d;
    logic          valid_q, valid_d;
    logic          timeout_q, timeout_d;
    logic          overrun_q, overrun_d;

    // State, assembly and output registers; reset drops any partial word silently.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            timer_q   <= '0;
            asm_q     <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            asm_q     <= asm_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state: byte placement, completion/overrun, idle timeout, output handshake.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timer_d   = timer_q;
        asm_d     = asm_q;
        word_d    = word_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        overrun_d = 1'b0;

        // Accept frees the output; a same-cycle load below overrides this.
        if (valid_q && i_Word_Ready) begin
            valid_d = 1'b0;
        end

        if (i_Rx_DV) begin
            // Byte slot is chosen by the current count; merging into asm_d
            // lets the final byte go straight into the output word.
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (cnt_q == CW'(k)) begin
                    if (LSB_FIRST != 0) begin
                        asm_d[8*k +: 8] = i_Rx_Byte;
                    end else begin
                        asm_d[W-8-8*k +: 8] = i_Rx_Byte;
                    end
                end
            end
            timer_d = '0;
            // IDLE always has count 0, which is never the last slot (NUM_BYTES >= 2).
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                state_d = IDLE;
                if (!valid_q || i_Word_Ready) begin
                    word_d  = asm_d;
                    valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end else begin
                cnt_d   = cnt_q + CW'(1);
                state_d = COLLECT;
            end
        end else if (state_q == COLLECT && TIMEOUT_CLKS > 0) begin
            if (timer_q == T_LAST) begin
                state_d   = IDLE;
                cnt_d     = '0;
                timer_d   = '0;
                timeout_d = 1'b1;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    assign o_Word       = word_q;
    assign o_Word_Valid = valid_q;
    assign o_Timeout    = timeout_q;
    assign o_Overrun    = overrun_q;
    assign o_Byte_Count = cnt_q;

endmodule

// File: tb/tb_word_assembler_rx.sv
// Directed bench: little-endian and big-endian 4-byte assemblers sharing one
// byte stream (100-clock timeout), plus a 2-byte big-endian instance with the
// timeout disabled.
module tb_word_assembler_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       dv, dv2;
    logic [7:0] byt, byt2;
    logic       rdy;

    logic [31:0] le_word, be_word;
    logic        le_valid, be_valid, le_to, be_to, le_ov, be_ov;
    logic [2:0]  le_cnt, be_cnt;
    logic [15:0] b2_word;
    logic        b2_valid, b2_to, b2_ov;
    logic [1:0]  b2_cnt;

    int checks = 0;
    int errors = 0;
    logic seen_to;

    word_assembler_rx #(.NUM_BYTES(4), .LSB_FIRST(1), .TIMEOUT_CLKS(100)) u_le (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Rx_DV(dv), .i_Rx_Byte(byt),
        .o_Word(le_word), .o_Word_Valid(le_valid), .i_Word_Ready(rdy),
        .o_Timeout(le_to), .o_Overrun(le_ov), .o_Byte_Count(le_cnt));

    word_assembler_rx #(.NUM_BYTES(4), .LSB_FIRST(0), .TIMEOUT_CLKS(100)) u_be (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Rx_DV(dv), .i_Rx_Byte(byt),
        .o_Word(be_word), .o_Word_Valid(be_valid), .i_Word_Ready(rdy),
        .o_Timeout(be_to), .o_Overrun(be_ov), .o_Byte_Count(be_cnt));

    word_assembler_rx #(.NUM_BYTES(2), .LSB_FIRST(0), .TIMEOUT_CLKS(0)) u_b2 (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Rx_DV(dv2), .i_Rx_Byte(byt2),
        .o_Word(b2_word), .o_Word_Valid(b2_valid), .i_Word_Ready(1'b1),
        .o_Timeout(b2_to), .o_Overrun(b2_ov), .o_Byte_Count(b2_cnt));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One strobe sampled on the next posedge; returns at the following negedge
    // so registered outputs of that edge are visible.
    task automatic send_byte(input logic [7:0] b, input logic r);
        @(negedge clk);
        dv  = 1'b1;
        byt = b;
        rdy = r;
        @(negedge clk);
        dv  = 1'b0;
    endtask

    task automatic send2(input logic [7:0] b);
        @(negedge clk);
        dv2  = 1'b1;
        byt2 = b;
        @(negedge clk);
        dv2  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; dv = 1'b0; byt = 8'h00; rdy = 1'b1; dv2 = 1'b0; byt2 = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_word",  le_word, 32'h0);
        check("rst_valid", 32'(le_valid), 32'd0);
        check("rst_cnt",   32'(le_cnt), 32'd0);
        check("rst_to",    32'(le_to), 32'd0);
        check("rst_ov",    32'(le_ov), 32'd0);
        rst_n = 1'b1;

        // Basic little/big endian assembly, ready high
        send_byte(8'h11, 1'b1); check("t1_cnt1", 32'(le_cnt), 32'd1);
        send_byte(8'h22, 1'b1); check("t1_cnt2", 32'(le_cnt), 32'd2);
        send_byte(8'h33, 1'b1); check("t1_cnt3", 32'(le_cnt), 32'd3);
        check("t1_valid_early", 32'(le_valid), 32'd0);
        send_byte(8'h44, 1'b1);
        check("t1_cnt0",   32'(le_cnt), 32'd0);
        check("t1_valid",  32'(le_valid), 32'd1);
        check("t1_le_word", le_word, 32'h44332211);
        check("t1_be_word", be_word, 32'h11223344);
        @(negedge clk);
        check("t1_valid_drop", 32'(le_valid), 32'd0);
        check("t1_be_valid_drop", 32'(be_valid), 32'd0);
        check("t1_word_kept", le_word, 32'h44332211);

        // Two-byte big endian, timeout disabled
        send2(8'hAB); check("b2_cnt1", 32'(b2_cnt), 32'd1);
        send2(8'hCD);
        check("b2_word",  32'(b2_word), 32'h0000ABCD);
        check("b2_valid", 32'(b2_valid), 32'd1);
        send2(8'hEE);
        repeat (20) @(negedge clk);
        check("b2_no_to_cnt", 32'(b2_cnt), 32'd1);
        check("b2_no_to",     32'(b2_to), 32'd0);
        send2(8'hFF);
        check("b2_word2", 32'(b2_word), 32'h0000EEFF);

        // Timeout: 100 idle clocks after the second byte
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        repeat (99) @(negedge clk);
        check("to_not_yet", 32'(le_to), 32'd0);
        check("to_cnt_held", 32'(le_cnt), 32'd2);
        @(negedge clk);
        check("to_pulse", 32'(le_to), 32'd1);
        check("to_cnt0",  32'(le_cnt), 32'd0);
        check("to_be_pulse", 32'(be_to), 32'd1);
        @(negedge clk);
        check("to_pulse_end", 32'(le_to), 32'd0);
        send_byte(8'hA0, 1'b1);
        send_byte(8'hA1, 1'b1);
        send_byte(8'hA2, 1'b1);
        send_byte(8'hA3, 1'b1);
        check("to_le_word", le_word, 32'hA3A2A1A0);
        check("to_be_word", be_word, 32'hA0A1A2A3);
        check("to_valid",   32'(le_valid), 32'd1);
        @(negedge clk);

        // Byte arriving exactly on the expiry cycle wins
        send_byte(8'h10, 1'b1);
        send_byte(8'h20, 1'b1);
        repeat (98) @(negedge clk);
        send_byte(8'h30, 1'b1);
        check("bnd_no_to", 32'(le_to), 32'd0);
        check("bnd_cnt3",  32'(le_cnt), 32'd3);
        @(negedge clk);
        check("bnd_no_to2", 32'(le_to), 32'd0);
        send_byte(8'h40, 1'b1);
        check("bnd_word", le_word, 32'h40302010);
        @(negedge clk);
        check("bnd_valid_drop", 32'(le_valid), 32'd0);

        // Overrun with ready low, then back-to-back load with ready high
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        check("ov_word1",  le_word, 32'h04030201);
        check("ov_valid1", 32'(le_valid), 32'd1);
        send_byte(8'h05, 1'b0);
        send_byte(8'h06, 1'b0);
        send_byte(8'h07, 1'b0);
        check("ov_held", le_word, 32'h04030201);
        check("ov_none_yet", 32'(le_ov), 32'd0);
        send_byte(8'h08, 1'b0);
        check("ov_pulse",    32'(le_ov), 32'd1);
        check("ov_word_kept", le_word, 32'h04030201);
        check("ov_be_kept",   be_word, 32'h01020304);
        check("ov_valid_kept", 32'(le_valid), 32'd1);
        check("ov_cnt0",     32'(le_cnt), 32'd0);
        @(negedge clk);
        check("ov_pulse_end", 32'(le_ov), 32'd0);
        send_byte(8'h09, 1'b0);
        send_byte(8'h0A, 1'b0);
        send_byte(8'h0B, 1'b0);
        send_byte(8'h0C, 1'b1);
        check("b2b_word",  le_word, 32'h0C0B0A09);
        check("b2b_valid", 32'(le_valid), 32'd1);
        check("b2b_no_ov", 32'(le_ov), 32'd0);
        @(negedge clk);
        check("b2b_accept", 32'(le_valid), 32'd0);

        // Reset mid-word
        send_byte(8'hE1, 1'b1);
        send_byte(8'hE2, 1'b1);
        check("rw_cnt2", 32'(le_cnt), 32'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rw_word",  le_word, 32'h0);
        check("rw_valid", 32'(le_valid), 32'd0);
        check("rw_cnt",   32'(le_cnt), 32'd0);
        check("rw_to",    32'(le_to), 32'd0);
        check("rw_ov",    32'(le_ov), 32'd0);
        check("rw_b2word", 32'(b2_word), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen_to = 1'b0;
        repeat (110) begin
            @(negedge clk);
            seen_to = seen_to | le_to | be_to;
        end
        check("rw_no_timeout", 32'(seen_to), 32'd0);
        send_byte(8'h55, 1'b1); check("rw_cnt_a", 32'(le_cnt), 32'd1);
        send_byte(8'h66, 1'b1); check("rw_cnt_b", 32'(le_cnt), 32'd2);
        send_byte(8'h77, 1'b1); check("rw_cnt_c", 32'(le_cnt), 32'd3);
        send_byte(8'h88, 1'b1);
        check("rw_word_new", le_word, 32'h88776655);
        check("rw_valid_new", 32'(le_valid), 32'd1);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
